// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: one registered grant at a time, with a two-cycle release gap gated by mem_ready.
// Optional grant watchdog built only when ARB_TIMEOUT_EN is defined.
module bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] rq,
  input  logic                   mem_ready,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [2:0]             owner,
  output logic                   bus_busy,
  output logic                   timeout
);

  localparam int IW = $clog2(NUM_MASTERS);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
    $error("bus_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, GRANTED, RELEASE} state_t;

  state_t                 state, state_next;
  logic [IW-1:0]          cur, cur_next;
  logic [IW-1:0]          last, last_next;
  logic [NUM_MASTERS-1:0] grant_next;
  logic [NUM_MASTERS-1:0] eligible;
  logic [IW-1:0]          pick;
  logic                   pick_vld;

  // Returns {found, index}; scanning from farthest to nearest lets the nearest requester after prev win.
  function automatic logic [IW:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                          input logic [IW-1:0]          prev);
    logic [IW:0] res;
    int          c;
    res = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      c = int'(prev) + k;
      if (c >= NUM_MASTERS) c = c - NUM_MASTERS;
      if (req[c[IW-1:0]]) res = {1'b1, c[IW-1:0]};
    end
    return res;
  endfunction

`ifdef ARB_TIMEOUT_EN
  logic [15:0]            count, count_next;
  logic [NUM_MASTERS-1:0] blocked, blocked_next;
  logic                   timeout_next;

  // A revoked master stays ineligible until it drops its request.
  assign eligible = rq & ~blocked;
`else
  assign eligible = rq;
  assign timeout  = 1'b0;
`endif

  assign {pick_vld, pick} = rr_pick(eligible, last);
  assign owner            = 3'(cur);

  always_comb begin
    state_next = state;
    grant_next = grant;
    cur_next   = cur;
    last_next  = last;
`ifdef ARB_TIMEOUT_EN
    count_next   = count;
    blocked_next = blocked & rq;
    timeout_next = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (pick_vld && !mem_ready) begin
          grant_next = NUM_MASTERS'(1) << pick;
          cur_next   = pick;
          state_next = GRANTED;
`ifdef ARB_TIMEOUT_EN
          count_next = '0;
`endif
        end
      end
      GRANTED: begin
        if (!rq[cur]) begin
          grant_next = '0;
          last_next  = cur;
          state_next = RELEASE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (count == 16'(TIMEOUT_CYCLES - 1)) begin
          grant_next   = '0;
          last_next    = cur;
          state_next   = RELEASE;
          timeout_next = 1'b1;
          blocked_next = blocked_next | (NUM_MASTERS'(1) << cur);
        end else begin
          count_next = count + 16'd1;
        end
`endif
      end
      RELEASE: begin
        if (!mem_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      cur      <= '0;
      last     <= IW'(NUM_MASTERS - 1);
      bus_busy <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      count    <= '0;
      blocked  <= '0;
      timeout  <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      grant    <= grant_next;
      cur      <= cur_next;
      last     <= last_next;
      bus_busy <= |grant_next;
`ifdef ARB_TIMEOUT_EN
      count    <= count_next;
      blocked  <= blocked_next;
      timeout  <= timeout_next;
`endif
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a behavioural arbitration model.
module tb_bus_arbiter;

  localparam int N = 4;
  localparam int T = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] rq;
  logic         mem_ready;
  logic [N-1:0] grant;
  logic [2:0]   owner;
  logic         bus_busy;
  logic         timeout;

  always #5 clk = ~clk;

  bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .rq(rq), .mem_ready(mem_ready),
    .grant(grant), .owner(owner), .bus_busy(bus_busy), .timeout(timeout)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a bus is either free, held by one master, or cooling down after a release.
  localparam int FREE = 0, HOLD = 1, COOL = 2;
  int m_phase = FREE, m_owner = 0, m_last = N - 1, m_held = 0, m_pick, m_c;
  bit m_busy = 1'b0, m_to = 1'b0;
  bit m_blk [N];
  bit m_elig [N];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = FREE; m_owner = 0; m_last = N - 1; m_held = 0; m_busy = 1'b0; m_to = 1'b0;
      for (int i = 0; i < N; i++) m_blk[i] = 1'b0;
    end else begin
      m_to = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_elig[i] = rq[i] && !m_blk[i];
`ifdef ARB_TIMEOUT_EN
        if (!rq[i]) m_blk[i] = 1'b0;
`endif
      end
      case (m_phase)
        FREE: if (!mem_ready) begin
          m_pick = -1;
          for (int k = 1; k <= N; k++) begin
            m_c = (m_last + k) % N;
            if (m_pick < 0 && m_elig[m_c]) m_pick = m_c;
          end
          if (m_pick >= 0) begin
            m_busy = 1'b1; m_owner = m_pick; m_held = 1; m_phase = HOLD;
          end
        end
        HOLD: if (!rq[m_owner]) begin
          m_busy = 1'b0; m_last = m_owner; m_phase = COOL;
        end
`ifdef ARB_TIMEOUT_EN
        else if (m_held == T) begin
          m_busy = 1'b0; m_last = m_owner; m_phase = COOL; m_to = 1'b1; m_blk[m_owner] = 1'b1;
        end
`endif
        else m_held++;
        default: if (!mem_ready) m_phase = FREE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      check("grant", grant, m_busy ? (32'd1 << m_owner) : 32'd0);
      check("owner", owner, m_owner);
      check("bus_busy", bus_busy, m_busy);
      check("timeout", timeout, m_to);
      check("onehot", $countones(grant) <= 1, 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [N-1:0] exp_seq [5];
  logic [N-1:0] obit;
  int zeros, waited, held, tos;

  initial begin
    reset = 1'b1; rq = '0; mem_ready = 1'b0;
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
    do_reset();
    cmp_en = 1'b1;

    check("rst_grant", grant, 0);
    check("rst_owner", owner, 0);
    check("rst_busy", bus_busy, 0);
    check("rst_timeout", timeout, 0);

    // Single requester right after reset.
    rq = 4'b0001;
    tick();
    check("first_grant", grant, 4'b0001);
    check("first_owner", owner, 0);
    check("first_busy", bus_busy, 1);

    // Round-robin rotation with every master requesting.
    do_reset();
    rq = 4'b1111;
    zeros = 0;
    for (int r = 0; r < 5; r++) begin
      if (r > 0) begin
        obit = grant;
        tick();
        tick();
        rq = rq & ~obit;
        tick();
        rq = rq | obit;
        zeros = (grant == 0) ? 1 : 0;
      end
      waited = 0;
      do begin
        tick();
        waited++;
        if (grant == 0) zeros++;
      end while (grant == 0 && waited < 20);
      check("rr_seq", grant, exp_seq[r]);
      if (r > 0) check("rr_gap", zeros, 2);
    end

    // Release while memory is busy: no grant until mem_ready falls, then two edges.
    do_reset();
    rq = 4'b0010;
    tick();
    check("mr_grant1", grant, 4'b0010);
    mem_ready = 1'b1;
    rq = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mr_hold0", grant, 0);
    end
    mem_ready = 1'b0;
    tick();
    check("mr_edge1", grant, 0);
    tick();
    check("mr_grant2", grant, 4'b0100);

    // Asynchronous reset in the middle of a grant.
    #1 reset = 1'b1;
    #1;
    check("async_grant", grant, 0);
    check("async_busy", bus_busy, 0);
    check("async_owner", owner, 0);
    tick();
    reset = 1'b0;
    rq = 4'b1010;
    tick();
    check("post_rst_grant", grant, 4'b0010);

    // Watchdog behaviour (or its absence).
    do_reset();
    rq = 4'b0011;
    tick();
    check("wd_first", grant, 4'b0001);
    held = 1; tos = 0;
`ifdef ARB_TIMEOUT_EN
    for (int n = 0; n < 40; n++) begin
      tick();
      if (timeout) tos++;
      if (grant == 4'b0001) held++;
      else if (grant == 4'b0010) break;
    end
    check("wd_held", held, T);
    check("wd_pulses", tos, 1);
    check("wd_next", grant, 4'b0010);
`else
    for (int n = 0; n < 120; n++) begin
      tick();
      if (timeout) tos++;
      if (grant == 4'b0001) held++;
    end
    check("nowd_held", held, 121);
    check("nowd_timeout", tos, 0);
`endif

    // Randomized traffic with level-held requests and occasional async resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(7) == 0) rq = rq ^ (N'(1) << i);
      mem_ready = ($urandom_range(2) == 0);
      tick();
      if ($urandom_range(699) == 0) begin
        #1 reset = 1'b1;
        tick();
        reset = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
